bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

Sequential BCD-to-binary converter: the inverse of the binary-to-BCD display path. Accepts nine packed BCD digits (BCD8 most significant), converts them digit-serially by multiply-by-10-and-accumulate, and presents a 36-bit unsigned binary result with a start/busy/done handshake. It sits between keypad/BCD entry logic and the arithmetic datapath that consumes 36-bit binary operands.

## Interface

Parameters:
- None. Digit count is fixed at 9 and the result width is fixed at 36.

Ports:
- `Clk`  in  1  system clock; all state changes on rising edge.
- `Rst_n`  in  1  synchronous, active-low reset, sampled on the `Clk` rising edge.
- `start`  in  1  request conversion; sampled only in IDLE.
- `BCD0`..`BCD8`  in  4 each  BCD digits; `BCD0` = units, `BCD8` = 10^8. Sampled only on the edge that accepts `start`.
- `data`  out  36  binary result; holds last completed value.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `data` is updated.
- `error`  out  1  invalid-digit flag; see Configuration.

## Operation

- Single clock domain; one clock; reset is synchronous and active-low.
- FSM states: IDLE, CONV.
  - IDLE: on `start`=1, capture `{BCD8..BCD0}` into a 36-bit digit shift register, clear accumulator `acc` (36 b) and digit counter `cnt` (4 b), set `busy`, clear `error`, go to CONV.
  - CONV: each cycle `acc <= (acc<<3) + (acc<<1) + dreg[35:32]`; `dreg <= dreg<<4`; `cnt <= cnt+1`. On the cycle where `cnt`=8 (ninth digit), load `data` with the new accumulator value, pulse `done`, clear `busy`, return to IDLE.
- Arithmetic: unsigned, 36-bit, no saturation. Max valid result 999,999,999 (30 bits); upper 6 bits of `data` are 0 for valid input.
- `start` while in CONV: ignored; no queuing.
- Input digits are not re-sampled after capture; changes during CONV have no effect.
- `data` is unchanged until the next `done`.
- Reset (`Rst_n`=0 at any edge, including mid-CONV): state IDLE, `acc`, `dreg`, `cnt` = 0; `data` = 0, `busy` = 0, `done` = 0, `error` = 0. An aborted conversion never produces `done`.

## Timing

- Edge E0 samples `start`=1 in IDLE → `busy`=1 after E0.
- Edges E1..E9 process BCD8..BCD0 respectively.
- After E9: `data` valid, `done`=1 for exactly one cycle, `busy`=0, state IDLE.
- Latency from start-accept edge to `done`: 9 cycles. Throughput: one conversion per 10 cycles (`start` held high re-triggers at E10).
- `error` is updated together with `done` and held until the next accepted `start`.

## Configuration

- Macro `BCD2BIN_DIGIT_CHECK_EN`.
- Defined: the captured digits are checked; if any nibble > 9, then at `done` `error`=1 and `data` = 0 (the accumulated value is discarded). Valid input gives `error`=0.
- Undefined: no check; `error` tied to 0; invalid nibbles are accumulated arithmetically at face value (e.g. 0xA counts as 10).

## Test plan

- Digits 6,5,0,3,4,5,7,6,8 (BCD8→BCD0), `start` pulse → `done` exactly 9 cycles later, `data`=36'd650345768, `busy` high for 9 cycles.
- All digits 9 → `data`=36'd999999999 (0x03B9AC9FF); followed by all digits 0 → `data`=0, `done` pulsed both times.
- Start 1234593, then pulse `start` and change all digits to 9 at cycle 3 → only one `done`, `data`=36'd1234593; `start` on the cycle after `done` with 566789321 → second `done` 9 cycles later, `data`=36'd566789321.
- `BCD3`=4'hA, other digits 0: with `BCD2BIN_DIGIT_CHECK_EN` → `error`=1, `data`=0; without → `error`=0, `data`=36'd10000.
- Start a conversion of 650345768, assert `Rst_n`=0 at cycle 4 for one cycle → `busy`=0, `data`=0, and no `done` within the following 20 cycles.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Digit-serial BCD-to-binary converter: nine packed BCD digits in, 36-bit unsigned result out.
// Optional invalid-digit checking is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        start,
  input  logic [3:0]  BCD0,
  input  logic [3:0]  BCD1,
  input  logic [3:0]  BCD2,
  input  logic [3:0]  BCD3,
  input  logic [3:0]  BCD4,
  input  logic [3:0]  BCD5,
  input  logic [3:0]  BCD6,
  input  logic [3:0]  BCD7,
  input  logic [3:0]  BCD8,
  output logic [35:0] data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [35:0] r_acc;
  logic [35:0] w_accNext;
  logic [35:0] r_dreg;
  logic [35:0] w_dregNext;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cntNext;
  logic [35:0] r_data;
  logic [35:0] w_dataNext;
  logic        r_busy;
  logic        w_busyNext;
  logic        r_done;
  logic        w_doneNext;
  logic [35:0] w_digits;
  logic [35:0] w_accStep;

  assign w_digits  = {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
  // acc*10 as shift-and-add, most significant digit consumed first
  assign w_accStep = (r_acc << 3) + (r_acc << 1) + {32'd0, r_dreg[35:32]};

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic r_bad;
  logic r_error;
  logic w_badIn;
  logic w_badNext;
  logic w_errorNext;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_dreg  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_acc   <= w_accNext;
      r_dreg  <= w_dregNext;
      r_cnt   <= w_cntNext;
      r_data  <= w_dataNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accNext   = r_acc;
    w_dregNext  = r_dreg;
    w_cntNext   = r_cnt;
    w_dataNext  = r_data;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_dregNext  = w_digits;
          w_accNext   = '0;
          w_cntNext   = '0;
          w_busyNext  = 1'b1;
          w_stateNext = S_CONV;
        end
      end
      S_CONV: begin
        w_accNext  = w_accStep;
        w_dregNext = r_dreg << 4;
        w_cntNext  = r_cnt + 4'd1;
        if (r_cnt == 4'd8) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
          w_dataNext = r_bad ? 36'd0 : w_accStep;
`else
          w_dataNext = w_accStep;
`endif
          w_doneNext  = 1'b1;
          w_busyNext  = 1'b0;
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  // Flag any nibble above 9 at capture; reported only when the result is published
  always_comb begin
    w_badIn = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (w_digits[4*i +: 4] > 4'd9) w_badIn = 1'b1;
    end
  end

  always_comb begin
    w_badNext   = r_bad;
    w_errorNext = r_error;
    if (r_state == S_IDLE && start) begin
      w_badNext   = w_badIn;
      w_errorNext = 1'b0;
    end else if (r_state == S_CONV && r_cnt == 4'd8) begin
      w_errorNext = r_bad;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_bad   <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_bad   <= w_badNext;
      r_error <= w_errorNext;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign data = r_data;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: vector table, hand-written corner sequences,
// and randomized conversions against an arithmetic reference model.
module tb_bcd_to_binary;

  logic        Clk;
  logic        Rst_n;
  logic        start;
  logic [3:0]  BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7, BCD8;
  logic [35:0] data;
  logic        busy;
  logic        done;
  logic        error;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [35:0] lastData = '0;

  bcd_to_binary dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .start (start),
    .BCD0  (BCD0),
    .BCD1  (BCD1),
    .BCD2  (BCD2),
    .BCD3  (BCD3),
    .BCD4  (BCD4),
    .BCD5  (BCD5),
    .BCD6  (BCD6),
    .BCD7  (BCD7),
    .BCD8  (BCD8),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string       name;
    logic [35:0] digs;
    logic [35:0] expData;
    logic        expErr;
  } vec_t;

  // Positional-value reference: sum of digit * 10^position, at face value
  function automatic logic [35:0] refData(input logic [35:0] d);
    logic [63:0] v;
    logic [63:0] p;
    logic        bad;
    v = 0;
    p = 1;
    bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v = v + 64'(d[4*i +: 4]) * p;
      p = p * 10;
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
    end
`ifdef BCD2BIN_DIGIT_CHECK_EN
    if (bad) v = 0;
`endif
    return v[35:0];
  endfunction

  function automatic logic refErr(input logic [35:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
    end
`ifdef BCD2BIN_DIGIT_CHECK_EN
    return bad;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setDigits(input logic [35:0] d);
    {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0} = d;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge that raises done
  task automatic applyStimulus(input string tag, input logic [35:0] d,
                               input logic [35:0] expData, input logic expErr);
    int lat;
    bit seen;
    bit busyOk;
    setDigits(d);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    checkOutput({tag, ".busyAfterStart"}, 64'(busy), 64'd1);
    checkOutput({tag, ".doneAfterStart"}, 64'(done), 64'd0);
    checkOutput({tag, ".errClearedAtStart"}, 64'(error), 64'd0);
    checkOutput({tag, ".dataHeld"}, 64'(data), 64'(lastData));
    lat = 0;
    seen = 1'b0;
    busyOk = 1'b1;
    while (!seen && lat < 30) begin
      setDigits(36'(~d));
      @(posedge Clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (busy !== 1'b1) busyOk = 1'b0;
    end
    checkOutput({tag, ".latency"}, 64'(lat), 64'd9);
    checkOutput({tag, ".busyHeld"}, 64'(busyOk), 64'd1);
    checkOutput({tag, ".busyAtDone"}, 64'(busy), 64'd0);
    checkOutput({tag, ".data"}, 64'(data), 64'(expData));
    checkOutput({tag, ".error"}, 64'(error), 64'(expErr));
    lastData = expData;
  endtask

  vec_t vecs[6];

  initial begin
    logic [35:0] d;
    int doneCount;
    int lat;
    bit seen;

    vecs[0] = '{"mixed",   36'h650345768, 36'd650345768, 1'b0};
    vecs[1] = '{"allNine", 36'h999999999, 36'd999999999, 1'b0};
    vecs[2] = '{"allZero", 36'h000000000, 36'd0,         1'b0};
    vecs[3] = '{"one",     36'h000000001, 36'd1,         1'b0};
    vecs[4] = '{"msdOnly", 36'h100000000, 36'd100000000, 1'b0};
`ifdef BCD2BIN_DIGIT_CHECK_EN
    vecs[5] = '{"badBcd3", 36'h00000A000, 36'd0,         1'b1};
`else
    vecs[5] = '{"badBcd3", 36'h00000A000, 36'd10000,     1'b0};
`endif

    Rst_n = 1'b0;
    start = 1'b0;
    setDigits('0);
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset.data", 64'(data), 64'd0);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.error", 64'(error), 64'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].name, vecs[i].digs, vecs[i].expData, vecs[i].expErr);
      @(posedge Clk); #1;
      checkOutput({vecs[i].name, ".donePulse"}, 64'(done), 64'd0);
      @(posedge Clk); #1;
      checkOutput({vecs[i].name, ".errorHeld"}, 64'(error), 64'(vecs[i].expErr));
      checkOutput({vecs[i].name, ".dataIdle"}, 64'(data), 64'(vecs[i].expData));
    end

    // start pulsed and digits changed mid-conversion must be ignored
    setDigits(36'h001234593);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    start = 1'b1;
    setDigits(36'h999999999);
    @(posedge Clk); #1;
    start = 1'b0;
    lat = 3;
    seen = 1'b0;
    doneCount = 0;
    while (!seen && lat < 30) begin
      @(posedge Clk); #1;
      lat++;
      if (done) begin
        seen = 1'b1;
        doneCount++;
      end
    end
    checkOutput("ignoreStart.latency", 64'(lat), 64'd9);
    checkOutput("ignoreStart.doneCount", 64'(doneCount), 64'd1);
    checkOutput("ignoreStart.data", 64'(data), 64'd1234593);
    lastData = 36'd1234593;
    applyStimulus("backToBack", 36'h566789321, 36'd566789321, 1'b0);

    // Synchronous reset mid-conversion aborts without a done
    @(posedge Clk); #1;
    setDigits(36'h650345768);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    checkOutput("abort.busy", 64'(busy), 64'd0);
    checkOutput("abort.data", 64'(data), 64'd0);
    doneCount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk); #1;
      if (done) doneCount++;
    end
    checkOutput("abort.noDone", 64'(doneCount), 64'd0);
    checkOutput("abort.dataStill", 64'(data), 64'd0);
    lastData = '0;

    // Randomized conversions, occasionally with an out-of-range nibble
    for (int r = 0; r < 20; r++) begin
      d = '0;
      for (int k = 0; k < 9; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) d[4*$urandom_range(0, 8) +: 4] = 4'($urandom_range(10, 15));
      applyStimulus($sformatf("rand%0d", r), d, refData(d), refErr(d));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge Clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
